// File: rtl/sm_fetch.sv
// Instruction fetch stage: owns the PC, reads the async ROM and buffers {instr, pc} in a prefetch queue.
// Define SM_FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module sm_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imAddr,
   input  logic [31:0] imData,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
`ifdef SM_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic             pop_c;
   logic             push_c;
   logic [1:0]       unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc[1:0];

   assign imAddr    = {2'b00, fetch_pc_q[31:2]};
   assign out_instr = ent_q[rd_ptr_q].instr;
   assign out_pc    = ent_q[rd_ptr_q].pc;

   // Handshake and queue bookkeeping; redirect overrides push and pop.
   always_comb begin
      out_valid  = (count_q != '0) && !redirect_valid;
      pop_c      = out_valid && out_ready;
      push_c     = fetch_en && !redirect_valid && ((count_q < CNT_W'(DEPTH)) || pop_c);
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ent_d      = ent_q;

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push_c) begin
            ent_d[wr_ptr_q] = '{instr: imData, pc: fetch_pc_q};
            fetch_pc_d      = fetch_pc_q + 32'd4;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ent_q      <= '{default: '0};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ent_q      <= ent_d;
      end
   end

`ifdef SM_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // A stall is a wanted fetch blocked only by a full queue.
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stall_d   = perf_stall_q;
      if (pop_c) begin
         perf_fetched_d = perf_fetched_q + 32'd1;
      end
      if (fetch_en && !redirect_valid && !push_c) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_sm_fetch.sv
// Scoreboard bench for sm_fetch: expected PCs are queued up front and compared on each handshake.
module tb_sm_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] imAddr;
   logic [31:0] imData;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef SM_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   // ROM model: word k holds 32'h1000_0000 + k
   assign imData = 32'h1000_0000 + imAddr;

   sm_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imAddr         (imAddr),
      .imData         (imData),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef SM_FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   function automatic logic [31:0] exp_instr(input logic [31:0] pc);
      return 32'h1000_0000 + {2'b00, pc[31:2]};
   endfunction

   task automatic test_reset();
      rst_n          = 1'b0;
      fetch_en       = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #12;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
      n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      n_cmp++; if (imAddr !== 32'h0) begin n_bad++; $display("FAIL reset_imaddr: got %h want 0", imAddr); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      sb_q.delete();
      for (int k = 0; k < 5; k++) sb_q.push_back(32'(k * 4));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++; $display("FAIL stream_extra: got pc %h want none", out_pc);
            end else begin
               exp_pc = sb_q.pop_front();
               if (out_pc !== exp_pc || out_instr !== exp_instr(exp_pc)) begin
                  n_bad++; $display("FAIL stream_data: got %h/%h want %h/%h", out_pc, out_instr, exp_pc, exp_instr(exp_pc));
               end
            end
         end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL stream_left: got %0d pending want 0", sb_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_addr;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_redirect_valid: got %b want 0", out_valid); end
      sb_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         #1;
         exp_addr = (i < 2) ? 32'(i) : 32'd2;
         n_cmp++; if (imAddr !== exp_addr) begin n_bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, imAddr, exp_addr); end
         n_cmp++; if (out_valid !== (i >= 1)) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want %b", i, out_valid, (i >= 1)); end
         if (i >= 1) begin
            n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL bp_hold_pc[%0d]: got %h want 0", i, out_pc); end
         end
      end
      for (int k = 0; k < 6; k++) sb_q.push_back(32'(k * 4));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         n_cmp++; if (imAddr !== 32'(2 + i)) begin n_bad++; $display("FAIL bp_drain_addr[%0d]: got %h want %h", i, imAddr, 32'(2 + i)); end
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, out_valid); end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++; $display("FAIL bp_extra: got pc %h want none", out_pc);
            end else begin
               exp_pc = sb_q.pop_front();
               if (out_pc !== exp_pc || out_instr !== exp_instr(exp_pc)) begin
                  n_bad++; $display("FAIL bp_data: got %h/%h want %h/%h", out_pc, out_instr, exp_pc, exp_instr(exp_pc));
               end
            end
         end
      end
   endtask

   task automatic test_redirect(input logic [31:0] target, input string name);
      logic [31:0] base;
      base = {target[31:2], 2'b00};
      @(negedge clk);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_same_cycle_valid: got %b want 0", name, out_valid); end
      sb_q.delete();
      for (int k = 0; k < 3; k++) sb_q.push_back(base + 32'(k * 4));
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (imAddr !== {2'b00, base[31:2]}) begin n_bad++; $display("FAIL %s_fetch_addr: got %h want %h", name, imAddr, {2'b00, base[31:2]}); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_flushed: got %b want 0", name, out_valid); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid[%0d]: got %b want 1", name, j, out_valid); end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++; $display("FAIL %s_extra: got pc %h want none", name, out_pc);
            end else begin
               exp_pc = sb_q.pop_front();
               if (out_pc !== exp_pc || out_instr !== exp_instr(exp_pc)) begin
                  n_bad++; $display("FAIL %s_data: got %h/%h want %h/%h", name, out_pc, out_instr, exp_pc, exp_instr(exp_pc));
               end
            end
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_full_valid: got %b want 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
      n_cmp++; if (imAddr !== 32'h0) begin n_bad++; $display("FAIL ar_imaddr: got %h want 0", imAddr); end
      n_cmp++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_bad++; $display("FAIL ar_head: got %h/%h want 0/0", out_pc, out_instr); end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      sb_q.delete();
      sb_q.push_back(32'h0);
      sb_q.push_back(32'h4);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++; $display("FAIL ar_extra: got pc %h want none", out_pc);
            end else begin
               exp_pc = sb_q.pop_front();
               if (out_pc !== exp_pc || out_instr !== exp_instr(exp_pc)) begin
                  n_bad++; $display("FAIL ar_data: got %h/%h want %h/%h", out_pc, out_instr, exp_pc, exp_instr(exp_pc));
               end
            end
         end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL ar_left: got %0d pending want 0", sb_q.size()); end
   endtask

`ifdef SM_FETCH_PERF_EN
   task automatic test_perf();
      @(negedge clk);
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      n_cmp++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin n_bad++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetched, perf_stall); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 1; s <= 15; s++) begin
         @(negedge clk);
         if (s == 11) out_ready = 1'b0;
         if (s == 15) fetch_en = 1'b0;
      end
      #1;
      n_cmp++; if (perf_fetched !== 32'd10) begin n_bad++; $display("FAIL perf_fetched: got %0d want 10", perf_fetched); end
      n_cmp++; if (perf_stall !== 32'd3) begin n_bad++; $display("FAIL perf_stall: got %0d want 3", perf_stall); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect(32'h0000_0043, "redirect");
      test_redirect(32'hFFFF_FFFC, "wrap");
      test_async_reset();
`ifdef SM_FETCH_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
